// File: rtl/iram_loader_pkg.sv
// Shared types for the instruction-RAM program loader: FSM states and result codes.
package iram_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        VERIFY,
        CHECK,
        DONE
    } state_e;

    localparam int unsigned ERR_W = 2;

    localparam logic [ERR_W-1:0] ERR_OK     = 2'd0;
    localparam logic [ERR_W-1:0] ERR_BADCNT = 2'd1;
    localparam logic [ERR_W-1:0] ERR_ABORT  = 2'd2;
    localparam logic [ERR_W-1:0] ERR_CKSUM  = 2'd3;

endpackage

// File: rtl/iram_loader_cksum.sv
// 32-bit running sum register (modulo 2^32) with synchronous clear; clear wins over add.
module iram_loader_cksum (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add,
    input  logic [31:0] value,
    output logic [31:0] sum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= 32'h0;
        end else if (clr) begin
            sum <= 32'h0;
        end else if (add) begin
            sum <= sum + value;
        end
    end

endmodule

// File: rtl/iram_loader.sv
// Program-load controller: streams an image into instruction RAM port B and stalls the CPU meanwhile.
// Define IRAM_LOADER_VERIFY_EN to add read-back verification against a running checksum.
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096,
    parameter int unsigned CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CW-1:0]    word_count,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:2]      ram_addrb,
    output logic [31:0]      ram_dinb,
    output logic             ram_web,
    input  logic [31:0]      ram_doutb,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err
);

    localparam logic [29:0] BASE_W = BASE_ADDR[31:2];

    state_e          state;
    logic [CW-1:0]   n_words;
    logic [CW-1:0]   idx;
    logic            start_ok_c;

    assign start_ok_c = start && (word_count != '0) && (word_count <= CW'(MAX_WORDS));

`ifdef IRAM_LOADER_VERIFY_EN
    logic [31:0] wr_sum;
    logic [31:0] rd_sum;
    logic        rd_pend;
    logic        sum_clr_c;
    logic        wr_add_c;
    logic        rd_add_c;
    logic        cksum_bad_c;

    assign sum_clr_c   = (state == IDLE) && start_ok_c;
    assign wr_add_c    = (state == LOAD) && in_valid && in_ready && !abort;
    // read data lags its address by one cycle, so the first VERIFY cycle has nothing to add
    assign rd_add_c    = (state == VERIFY) && rd_pend && !abort;
    assign cksum_bad_c = (rd_sum + ram_doutb) != wr_sum;

    iram_loader_cksum u_wr_sum (
        .clk   (clk),
        .rst   (rst),
        .clr   (sum_clr_c),
        .add   (wr_add_c),
        .value (in_data),
        .sum   (wr_sum)
    );

    iram_loader_cksum u_rd_sum (
        .clk   (clk),
        .rst   (rst),
        .clr   (sum_clr_c),
        .add   (rd_add_c),
        .value (ram_doutb),
        .sum   (rd_sum)
    );
`else
    logic unused_doutb_c;
    assign unused_doutb_c = ^ram_doutb;
`endif

    // Load sequencer; every output is registered alongside the state it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            n_words   <= '0;
            idx       <= '0;
            in_ready  <= 1'b0;
            ram_addrb <= '0;
            ram_dinb  <= 32'h0;
            ram_web   <= 1'b0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= ERR_OK;
`ifdef IRAM_LOADER_VERIFY_EN
            rd_pend   <= 1'b0;
`endif
        end else begin
            ram_web <= 1'b0;
            done    <= 1'b0;
`ifdef IRAM_LOADER_VERIFY_EN
            rd_pend <= (state == VERIFY);
`endif
            if ((state != IDLE) && abort) begin
                state    <= IDLE;
                err      <= ERR_ABORT;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                cpu_hold <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok_c) begin
                            n_words  <= word_count;
                            idx      <= '0;
                            err      <= ERR_OK;
                            state    <= LOAD;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            cpu_hold <= 1'b1;
                        end else if (start) begin
                            err <= ERR_BADCNT;
                        end
                    end
                    LOAD: begin
                        if (in_valid && in_ready) begin
                            ram_web   <= 1'b1;
                            ram_addrb <= BASE_W + 30'(idx);
                            ram_dinb  <= in_data;
                            idx       <= idx + CW'(1);
                            if (idx + CW'(1) == n_words) begin
                                state    <= FLUSH;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                    FLUSH: begin
`ifdef IRAM_LOADER_VERIFY_EN
                        // issue the first read here so VERIFY holds exactly N read cycles
                        state     <= VERIFY;
                        ram_addrb <= BASE_W;
                        idx       <= CW'(1);
`else
                        state <= DONE;
                        done  <= 1'b1;
`endif
                    end
`ifdef IRAM_LOADER_VERIFY_EN
                    VERIFY: begin
                        if (idx == n_words) begin
                            state <= CHECK;
                        end else begin
                            ram_addrb <= BASE_W + 30'(idx);
                            idx       <= idx + CW'(1);
                        end
                    end
                    CHECK: begin
                        if (cksum_bad_c) begin
                            err <= ERR_CKSUM;
                        end
                        state <= DONE;
                        done  <= 1'b1;
                    end
`endif
                    DONE: begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iram_loader.sv
// Randomized bench for iram_loader: scoreboards port-B writes, done timing, busy windows and result codes.
// Timing expectations follow IRAM_LOADER_VERIFY_EN when it is defined.
module tb_iram_loader;

    localparam int unsigned MAX_WORDS = 16;
    localparam int unsigned CW        = $clog2(MAX_WORDS + 1);
    localparam logic [31:0] BASE_ADDR = 32'h0000_0102;
    localparam int          BASE_W    = int'(BASE_ADDR >> 2);
`ifdef IRAM_LOADER_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] word_count;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic [31:2]   ram_addrb;
    logic [31:0]   ram_dinb;
    logic          ram_web;
    logic [31:0]   ram_doutb;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic [1:0]    err;

    iram_loader #(
        .BASE_ADDR (BASE_ADDR),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ram_addrb  (ram_addrb),
        .ram_dinb   (ram_dinb),
        .ram_web    (ram_web),
        .ram_doutb  (ram_doutb),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model; can flip a bit of word 1 on write to emulate a bad cell
    logic [31:0] mem [0:255];
    bit          corrupt_en;

    always @(posedge clk) begin
        if (ram_web)
            mem[ram_addrb[9:2]] <= (corrupt_en && ram_addrb == 30'(BASE_W + 1))
                                   ? (ram_dinb ^ 32'h0000_0100) : ram_dinb;
        ram_doutb <= mem[ram_addrb[9:2]];
    end

    typedef struct {
        int          c;
        logic [29:0] a;
        logic [31:0] d;
    } wr_t;

    int   cyc = 0;
    wr_t  wr_q[$];
    int   done_q[$];
    bit   busy_h[int];
    bit   hold_h[int];
    bit   rdy_h[int];
    logic [31:0] img [0:MAX_WORDS-1];
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        busy_h[cyc] = busy;
        hold_h[cyc] = cpu_hold;
        rdy_h[cyc]  = in_ready;
        if (ram_web) wr_q.push_back('{cyc, ram_addrb, ram_dinb});
        if (done) done_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) img[i] = $urandom;
    endtask

    // Drive one load; gap < 0 means random 0..3 idle cycles before each word
    task automatic run_load(input string tag, input int n, input int gap, input int abort_idx,
                            input bit corrupt);
        int s, endc, exp_done, bend, budget, nw, bad_b, bad_h, bad_r;
        int hs[$];
        bit exp_b, exp_r;
        logic [31:0] expw;
        logic [1:0]  exp_err;
        wr_q.delete();
        done_q.delete();
        corrupt_en = corrupt;
        @(negedge clk);
        start = 1'b1; word_count = CW'(n); s = cyc;
        @(negedge clk);
        start = 1'b0; word_count = '0;
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(0, 3)) : ((i == 0) ? 0 : gap);
            repeat (g) @(negedge clk);
            in_valid = 1'b1;
            in_data  = img[i];
            abort    = (i == abort_idx);
            budget   = 0;
            while (!in_ready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            check({tag, " ready"}, 64'(in_ready), 64'(1));
            hs.push_back(cyc);
            @(negedge clk);
            in_valid = 1'b0;
            abort    = 1'b0;
            if (i == abort_idx) break;
        end
        budget = 0;
        while (abort_idx < 0 && done_q.size() == 0 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        repeat (4) @(negedge clk);
        endc     = cyc - 1;
        nw       = (abort_idx < 0) ? n : abort_idx;
        exp_done = hs[$] + 2 + (VERIFY_EN ? n + 1 : 0);
        bend     = (abort_idx < 0) ? exp_done : hs[$];
        check({tag, " writes"}, 64'(wr_q.size()), 64'(nw));
        for (int i = 0; i < nw && i < wr_q.size(); i++) begin
            expw = (corrupt && i == 1) ? (img[i] ^ 32'h0000_0100) : img[i];
            check({tag, " waddr"}, 64'(wr_q[i].a), 64'(BASE_W + i));
            check({tag, " wdata"}, 64'(wr_q[i].d), 64'(img[i]));
            check({tag, " wcyc"},  64'(wr_q[i].c), 64'(hs[i] + 1));
            check({tag, " ram"},   64'(mem[8'(BASE_W + i)]), 64'(expw));
        end
        check({tag, " dones"}, 64'(done_q.size()), 64'((abort_idx < 0) ? 1 : 0));
        if (abort_idx < 0 && done_q.size() > 0)
            check({tag, " done cyc"}, 64'(done_q[0]), 64'(exp_done));
        bad_b = 0; bad_h = 0; bad_r = 0;
        for (int c = s; c <= endc; c++) begin
            exp_b = (c > s) && (c <= bend);
            exp_r = (c > s) && (c <= hs[$]);
            if (busy_h[c] != exp_b) bad_b++;
            if (hold_h[c] != exp_b) bad_h++;
            if (rdy_h[c]  != exp_r) bad_r++;
        end
        check({tag, " busy window"}, 64'(bad_b), 64'(0));
        check({tag, " hold window"}, 64'(bad_h), 64'(0));
        check({tag, " ready window"}, 64'(bad_r), 64'(0));
        exp_err = (abort_idx >= 0) ? 2'd2 : ((corrupt && VERIFY_EN) ? 2'd3 : 2'd0);
        check({tag, " err"}, 64'(err), 64'(exp_err));
        corrupt_en = 1'b0;
    endtask

    task automatic bad_start(input string tag, input int cnt);
        int s, hi;
        wr_q.delete();
        done_q.delete();
        @(negedge clk);
        start = 1'b1; word_count = CW'(cnt); s = cyc;
        @(negedge clk);
        start = 1'b0; word_count = '0;
        repeat (4) @(negedge clk);
        hi = 0;
        for (int c = s; c < cyc; c++) if (busy_h[c] || hold_h[c]) hi++;
        check({tag, " err"}, 64'(err), 64'(1));
        check({tag, " busy cycles"}, 64'(hi), 64'(0));
        check({tag, " writes"}, 64'(wr_q.size()), 64'(0));
        check({tag, " dones"}, 64'(done_q.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; word_count = '0;
        in_valid = 1'b0; in_data = 32'h0; corrupt_en = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ctrl", 64'({in_ready, ram_web, cpu_hold, busy, done, err}), 64'(0));
        check("reset bus",  64'({ram_addrb, ram_dinb}), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;
        run_load("n4 b2b", 4, 0, -1, 1'b0);

        fill_rand(3);
        run_load("n3 gap2", 3, 2, -1, 1'b0);

        bad_start("cnt0", 0);
        bad_start("cnt max+1", MAX_WORDS + 1);

        fill_rand(5);
        run_load("abort hs2", 5, 0, 1, 1'b0);

        fill_rand(4);
        run_load("corrupt w1", 4, -1, -1, 1'b1);

        fill_rand(1);
        run_load("n1", 1, 0, -1, 1'b0);
        fill_rand(MAX_WORDS);
        run_load("nmax", MAX_WORDS, -1, -1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            int n;
            n = int'($urandom_range(1, MAX_WORDS));
            fill_rand(n);
            run_load($sformatf("rand%0d n%0d", k, n), n, -1, -1, 1'b0);
        end

        // Asynchronous reset in the middle of LOAD
        fill_rand(4);
        @(negedge clk);
        start = 1'b1; word_count = CW'(4);
        @(negedge clk);
        start = 1'b0; word_count = '0; in_valid = 1'b1; in_data = img[0];
        @(negedge clk);
        in_data = img[1];
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midload rst ctrl", 64'({in_ready, ram_web, cpu_hold, busy, done, err}), 64'(0));
        check("midload rst bus",  64'({ram_addrb, ram_dinb}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        fill_rand(2);
        run_load("post rst n2", 2, 0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
